// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU, one quotient bit per
// clock. Result is {remainder, quotient}; the remainder goes to HI and the
// quotient goes to LO.
// Optional build macro DIV_EARLY_OUT_EN: when defined, a divide whose
// dividend magnitude is smaller than the divisor magnitude completes from
// FREE in a single cycle.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {FREE, DIVZERO, ON, END} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  dvd;     // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]  rem;     // partial remainder
  logic [DATA_W-1:0]  dsr;     // divisor magnitude
  logic               neg_q;
  logic               neg_r;

  logic               op1_neg;
  logic               op2_neg;
  logic [DATA_W-1:0]  op1_mag;
  logic [DATA_W-1:0]  op2_mag;
  logic               early;
  logic [DATA_W:0]    shifted;
  logic [DATA_W:0]    trial;
  logic               qbit;
  logic [DATA_W-1:0]  rem_nxt;
  logic [DATA_W-1:0]  dvd_nxt;
  logic [DATA_W-1:0]  q_fix;
  logic [DATA_W-1:0]  r_fix;

  // Operand magnitudes, one restoring step, and sign fixup of the step result.
  // The fixup is applied to the final step's output so the result register
  // loads the signed answer on the same edge that enters END.
  always_comb begin
    op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    op1_mag = op1_neg ? ('0 - opdata1_i) : opdata1_i;
    op2_mag = op2_neg ? ('0 - opdata2_i) : opdata2_i;
`ifdef DIV_EARLY_OUT_EN
    early   = (op1_mag < op2_mag);
`else
    early   = 1'b0;
`endif
    shifted = {rem, dvd[DATA_W-1]};
    trial   = shifted - {1'b0, dsr};
    qbit    = ~trial[DATA_W];
    rem_nxt = qbit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    dvd_nxt = {dvd[DATA_W-2:0], qbit};
    q_fix   = neg_q ? ('0 - dvd_nxt) : dvd_nxt;
    r_fix   = neg_r ? ('0 - rem_nxt) : rem_nxt;
  end

  // Sequencer: accept, iterate DATA_W times, present result until start drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      dvd      <= '0;
      rem      <= '0;
      dsr      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            neg_q <= op1_neg ^ op2_neg;
            neg_r <= op1_neg;
            dsr   <= op2_mag;
            dvd   <= op1_mag;
            rem   <= '0;
            cnt   <= '0;
            if (opdata2_i == '0) begin
              state <= DIVZERO;
            end else if (early) begin
              // |dividend| < |divisor|: quotient 0, remainder is the dividend
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {opdata1_i, {DATA_W{1'b0}}};
            end else begin
              state <= ON;
            end
          end
        end
        DIVZERO: begin
          state    <= END;
          ready_o  <= 1'b1;
          result_o <= '0;
        end
        ON: begin
          if (annul_i) begin
            state    <= FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {r_fix, q_fix};
            end
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          state    <= FREE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

  // Stall request while a divide is actually computing.
  assign busy_o = (state == DIVZERO) || (state == ON);

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed bench for div_seq. A transaction-level reference
// (native division plus latency bookkeeping) predicts ready/busy/result on
// every cycle; directed tasks add hand-computed literal expectations.
module tb_div_seq;

  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                signed_div_i = 1'b0;
  logic [DATA_W-1:0]   opdata1_i = '0;
  logic [DATA_W-1:0]   opdata2_i = '0;
  logic                start_i = 1'b0;
  logic                annul_i = 1'b0;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                busy_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  div_seq #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference result: {remainder, quotient} via 64-bit signed arithmetic,
  // which truncates toward zero and gives the remainder the dividend's sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
    end else begin
      sa = $signed({32'd0, a});
      sb = $signed({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

`ifdef DIV_EARLY_OUT_EN
  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return (s && v[31]) ? (32'd0 - v) : v;
  endfunction
`endif

  // Reference timeline: cycles of busy left, then a held result.
  int          m_wait = 0;
  bit          m_hold = 1'b0;
  bit          m_zero = 1'b0;
  logic [63:0] m_res  = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin : model
    logic eo;
    eo = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    eo = (opdata2_i != 0) && (mag(opdata1_i, signed_div_i) < mag(opdata2_i, signed_div_i));
`endif
    if (rst) begin
      m_wait <= 0;
      m_hold <= 1'b0;
      m_zero <= 1'b0;
      m_res  <= '0;
    end else if (m_hold) begin
      if (!start_i || annul_i) begin
        m_hold <= 1'b0;
        m_res  <= '0;
      end
    end else if (m_wait != 0) begin
      if (annul_i && !m_zero) begin
        m_wait <= 0;
      end else begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin
          m_hold <= 1'b1;
          m_res  <= m_pend;
        end
      end
    end else if (start_i && !annul_i) begin
      m_pend <= ref_div(opdata1_i, opdata2_i, signed_div_i);
      m_zero <= (opdata2_i == 0);
      if (eo) begin
        m_hold <= 1'b1;
        m_res  <= ref_div(opdata1_i, opdata2_i, signed_div_i);
      end else begin
        m_wait <= (opdata2_i == 0) ? 1 : DATA_W;
      end
    end
  end

  // Per-cycle comparison against the reference timeline.
  always @(negedge clk) begin
    if (chk_en)
      chk("cycle", {ready_o, busy_o, result_o}, {m_hold, (m_wait != 0), m_res});
  end

  // One divide: wait for ready (bounded), check latency, busy cycles and
  // result, hold start for `hold` cycles, then drop start and check the clear.
  task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input int exp_lat,
                        input int hold);
    int n, nb;
    bit seen;
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1'b1;
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      // operands must be ignored once accepted
      opdata1_i = $urandom; opdata2_i = $urandom;
      if (busy_o) nb++;
      if (ready_o) seen = 1'b1;
    end
    chk({nm, "_lat"}, 66'(n), 66'(exp_lat));
    chk({nm, "_busy"}, 66'(nb), 66'(exp_lat - 1));
    chk({nm, "_res"}, 66'(result_o), 66'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold"}, 66'({ready_o, result_o}), 66'({1'b1, exp}));
    end
    start_i = 1'b0;
    @(negedge clk);
    chk({nm, "_clr"}, 66'({ready_o, result_o}), 66'd0);
  endtask

  initial begin
    int pulses;
    logic [63:0] pr;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset", 66'({ready_o, busy_o, result_o}), 66'd0);
    chk_en = 1'b1;

    // Pin the reference against hand-computed values
    chk("ref_100_7",  66'(ref_div(32'd100, 32'd7, 1'b0)), 66'(64'h00000002_0000000E));
    chk("ref_m7_2",   66'(ref_div(32'hFFFFFFF9, 32'd2, 1'b1)), 66'(64'hFFFFFFFF_FFFFFFFD));
    chk("ref_ovf",    66'(ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1)), 66'(64'h00000000_80000000));
    chk("ref_div0",   66'(ref_div(32'd5, 32'd0, 1'b0)), 66'd0);

    do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0);
    do_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    do_div("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 0);
    do_div("divu_5_0", 32'd5, 32'd0, 1'b0, 64'd0, 2, 0);

    // Annul mid-divide: no completion, then a fresh divide works
    @(negedge clk);
    opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    chk("annul_busy", 66'(busy_o), 66'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    chk("annul_noready", 66'(pulses), 66'd0);
    do_div("divu_9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 0);

    // Handshake hold, then back-to-back starts
    do_div("hold", 32'h12345678, 32'd1000, 1'b0, 64'h00000380_0004A90B, 33, 3);
    do_div("b2b_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 64'hFFFFFFFE_FFFFFFF2, 33, 0);
    do_div("b2b_100_m7", 32'd100, 32'hFFFFFFF9, 1'b1, 64'h00000002_FFFFFFF2, 33, 1);

    // start dropped during ON: divide still completes, ready for one cycle
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd10; signed_div_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    pulses = 0; pr = '0;
    repeat (60) begin
      @(negedge clk);
      if (ready_o) begin pulses++; pr = result_o; end
    end
    chk("drop_pulses", 66'(pulses), 66'd1);
    chk("drop_res", 66'(pr), 66'(64'h00000000_00000064));

    // Reset in the middle of a divide
    @(negedge clk);
    opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    chk("rst_mid", 66'({ready_o, busy_o, result_o}), 66'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o || busy_o) pulses++;
    end
    chk("rst_quiet", 66'(pulses), 66'd0);

    // Small dividend: early completion only when the option is built in
`ifdef DIV_EARLY_OUT_EN
    do_div("eo_3_10", 32'd3, 32'd10, 1'b0, 64'h00000003_00000000, 1, 1);
    do_div("eo_m3_10", 32'hFFFFFFFD, 32'd10, 1'b1, 64'hFFFFFFFD_00000000, 1, 0);
`else
    do_div("eo_3_10", 32'd3, 32'd10, 1'b0, 64'h00000003_00000000, 33, 1);
    do_div("eo_m3_10", 32'hFFFFFFFD, 32'd10, 1'b1, 64'hFFFFFFFD_00000000, 33, 0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
